// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM stream reader.
package ram_stream_reader_pkg;

  localparam int unsigned BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } state_t;

endpackage

// File: rtl/ram_rd_skid_buffer.sv
// Two-entry FIFO that absorbs the RAM read latency; entries carry {last, data}.
module ram_rd_skid_buffer
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occupancy,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push   = push && (count_q != 2'(BUF_DEPTH));
    do_pop    = pop && (count_q != 2'd0);
    head_data = mem_q[rd_ptr_q];
    occupancy = count_q;
    empty     = (count_q == 2'd0);
  end

  // Storage is cleared on flush so the head reads zero straight out of reset.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Command-driven RAM reader producing a valid/ready stream with a last marker.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  input  logic                  ram_rd_data_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  inflight_q, inflight_d;
  logic                  last_pend_q, last_pend_d;

  logic                  pop;
  logic                  capture;
  logic                  credit_ok;
  logic [2:0]            used;
  logic [1:0]            occupancy;
  logic                  buf_empty;
  logic                  buf_flush;
  logic [DATA_WIDTH:0]   head_data;

  assign buf_flush = !rst_n;
  assign pop       = m_valid && m_ready;
  assign capture   = ram_rd_data_valid && inflight_q;
  assign m_valid   = !buf_empty;
  assign m_last    = head_data[DATA_WIDTH];
  assign m_data    = head_data[DATA_WIDTH-1:0];
  assign ram_rd_addr = addr_q;

  // A read may issue only if its data is guaranteed a free buffer slot on return.
  always_comb begin
    used      = {1'b0, occupancy} + {2'b00, inflight_q};
    credit_ok = used < (3'd2 + {2'b00, pop});
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    ram_rd_en   = 1'b0;
    cmd_ready   = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          remain_d = cmd_len;
          state_d  = (cmd_len != '0) ? StRead : StDone;
        end
      end
      StRead: begin
        if (credit_ok) begin
          ram_rd_en = 1'b1;
          addr_d    = addr_q + ADDR_WIDTH'(1);
          remain_d  = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Leave as soon as the final word is being popped, not a cycle later.
        if (!inflight_q && (occupancy == 2'd0 || (occupancy == 2'd1 && pop))) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    inflight_d  = ram_rd_en ? 1'b1 : (capture ? 1'b0 : inflight_q);
    last_pend_d = ram_rd_en ? (remain_q == LEN_WIDTH'(1)) : last_pend_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remain_q    <= '0;
      inflight_q  <= 1'b0;
      last_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      inflight_q  <= inflight_d;
      last_pend_q <= last_pend_d;
    end
  end

  ram_rd_skid_buffer #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_buf (
    .clk      (clk),
    .flush    (buf_flush),
    .push     (capture),
    .push_data({last_pend_q, ram_rd_data}),
    .pop      (pop),
    .head_data(head_data),
    .occupancy(occupancy),
    .empty    (buf_empty)
  );

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Command-driven reader for the read port of `simple_dual_port_ram` built with `IS_OUT_LATENCY = "true"`. It accepts a start address and word count, issues RAM reads, and presents the words as a valid/ready stream with a last marker. A built-in two-entry buffer absorbs the one-cycle RAM read latency, so the block runs at full throughput under continuous `m_ready` and never loses or duplicates a word under backpressure. It sits between RAM-resident tables or frames and any downstream stream consumer.

## Interface
- `DATA_WIDTH`, 8: word width; matches the RAM.
- `ADDR_WIDTH`, 8: RAM address width; depth is 2**ADDR_WIDTH.
- `LEN_WIDTH`, ADDR_WIDTH+1: width of the word-count field.
- `clk`  in  1: single clock for all logic; connects to the RAM `rd_clk`.
- `rst_n`  in  1: reset, synchronous, active-low.
- `cmd_valid`  in  1: a command is offered.
- `cmd_ready`  out  1: block is idle and accepts a command.
- `cmd_addr`  in  ADDR_WIDTH: start address.
- `cmd_len`  in  LEN_WIDTH: number of words to read; 0 is legal.
- `ram_rd_en`  out  1: RAM read enable.
- `ram_rd_addr`  out  ADDR_WIDTH: RAM read address.
- `ram_rd_data`  in  DATA_WIDTH: RAM read data, one cycle after `ram_rd_en`.
- `ram_rd_data_valid`  in  1: RAM read data qualifier.
- `m_data`  out  DATA_WIDTH: stream data.
- `m_valid`  out  1: stream word valid.
- `m_ready`  in  1: downstream accepts the word.
- `m_last`  out  1: marks the final word of the command.
- `busy`  out  1: a command is in progress.
- `done`  out  1: one-cycle pulse when a command completes.

## Operation
- **States.**
  - IDLE: `cmd_ready=1`. A command is accepted when `cmd_valid && cmd_ready`; it latches the address and length. Next state is READ if `len > 0`, otherwise DONE.
  - READ: issues reads under the credit rule below. After the last read is issued, next state is DRAIN.
  - DRAIN: waits until no read is in flight and the buffer is empty, then goes to DONE.
  - DONE: `done=1` for one cycle, then IDLE.
- `busy` is 1 whenever the state is not IDLE.
- **Credit rule.** `ram_rd_en` is asserted only when `occupancy + inflight - pop < 2`, where:
  - `occupancy` is the number of buffer entries in use (0..2);
  - `inflight` is reads issued but not yet captured (0..1);
  - `pop` is `m_valid && m_ready`.
- **Address.** Increments modulo 2**ADDR_WIDTH after each issued read, so wrap-around is silent. A `cmd_len` above the RAM depth re-reads from the wrapped addresses.
- **Capture.** A word is written into the buffer only when `ram_rd_data_valid && inflight==1`. A stray `ram_rd_data_valid` is ignored.
- **Buffer.** First-in first-out. `m_valid` means the buffer is non-empty; `m_data`/`m_last` come from the head entry.
- **Last marker.** `m_last` is stored with the word that corresponds to the final issued read.
- **Reset values** (during and immediately after reset):
  - `cmd_ready=1`;
  - `ram_rd_en=0`, `ram_rd_addr=0`;
  - `m_valid=0`, `m_data=0`, `m_last=0`;
  - `busy=0`, `done=0`.
- **Reset mid-command.** Aborts the command: the buffer is flushed and the in-flight counter is cleared. RAM data returning in the cycle after reset is discarded.
- **Stream protocol.** Once asserted, `m_valid` with its `m_data`/`m_last` holds stable until the handshake completes.

## Timing
- Accept at edge 0, i.e. cycle 0 has `cmd_valid && cmd_ready`.
- First `ram_rd_en` is in cycle 1; the data arrives in cycle 2; `m_valid` first rises in cycle 3.
- With `m_ready` held high, one word is delivered per cycle. A command of N words has its last beat in cycle N+2 and `done` in cycle N+3.
- `cmd_ready` returns to 1 in cycle N+4.
- A `cmd_len` of 0: `done` in cycle 1, `cmd_ready` in cycle 2, no reads and no beats.
- Commands are not pipelined; one command is outstanding at a time.

## Structure
- Package `ram_stream_reader_pkg` holds:
  - the `state_t` enum (IDLE, READ, DRAIN, DONE);
  - `localparam BUF_DEPTH = 2`.
- Sub-module `ram_rd_skid_buffer`: a two-entry FIFO of {last, data} with push/pop, occupancy and flush. The top level holds the FSM, address/length counters and credit logic.

## Test plan
- **Reset.** Assert `rst_n=0` mid-idle. Outputs must be at the reset values listed above. On release, the first cycle shows `cmd_ready=1`.
- **Basic read.** Preload mem[i]=i. Issue cmd addr 0x10, len 4, with `m_ready=1`. Expect:
  - `ram_rd_en` in cycles 1-4 with addresses 0x10-0x13;
  - beats 0x10-0x13 in cycles 3-6, with `m_last` only on 0x13;
  - `done` in cycle 7.
- **Wrap-around.** With `ADDR_WIDTH=8`, issue cmd addr 0xFE, len 4. Read addresses must be FE, FF, 00, 01, and the beats must match the memory contents.
- **Backpressure.** Issue cmd len 8 with `m_ready` pattern 1,0,0,1,0,1,1,0,... Expect:
  - exactly 8 beats, in order;
  - no RAM read while credits are exhausted;
  - `m_data` stable while stalled.
- **Zero length.** Issue cmd len 0. Expect `done` in cycle 1, no `ram_rd_en`, no `m_valid`.
- **Reset mid-burst.** Issue a len 6 command and reset after 2 beats, with a forced `ram_rd_data_valid` in the cycle after reset. The stray data must not appear on the stream. A following cmd addr 0x20, len 2 must deliver exactly mem[0x20] and mem[0x21].
